// File: rtl/mips_sopc.sv
// mips_sopc: single-cycle MIPS-subset core ("cpu") fetching from a 4 KiB word-addressed ROM ("rom").
// Define SOPC_SHIFT_EN to decode SLL/SRL/SRA/SLLV/SRLV/SRAV; otherwise those encodings execute as NOPs.

module mips_sopc_rom (
   input  logic [9:0]  word_index,
   output logic [31:0] data
);

   // Contents are preloaded from outside; hardware never writes here.
   logic [31:0] storage [0:1023];

   assign data = storage[word_index];

endmodule


module mips_sopc_regfile (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  raddr_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_a,
   output logic [31:0] rdata_b,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] storage [0:31];

   // Writes to $0 are dropped so storage[0] stays at its reset value of zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            storage[i] <= '0;
         end
      end else if (we && (waddr != 5'd0)) begin
         storage[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : storage[raddr_a];
   assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : storage[raddr_b];

endmodule


module mips_sopc_cpu (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instr,
   output logic [9:0]  imem_index
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;

   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_NOR     = 6'h27;
   localparam logic [5:0] FN_SLT     = 6'h2A;
   localparam logic [5:0] FN_SLTU    = 6'h2B;
`ifdef SOPC_SHIFT_EN
   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_SLLV    = 6'h04;
   localparam logic [5:0] FN_SRLV    = 6'h06;
   localparam logic [5:0] FN_SRAV    = 6'h07;
`endif

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [31:0] jump_target;

   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;
`ifdef SOPC_SHIFT_EN
   logic [4:0]  shamt;
`endif

   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign funct    = instr[5:0];
   assign imm_sext = {{16{instr[15]}}, instr[15:0]};
   assign imm_zext = {16'd0, instr[15:0]};
`ifdef SOPC_SHIFT_EN
   assign shamt    = instr[10:6];
`endif

   assign pc_plus4      = pc_q + 32'd4;
   assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
   assign imem_index    = pc_q[11:2];

   mips_sopc_regfile register (
      .clock   (clock),
      .reset   (reset),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (rs_val),
      .rdata_b (rt_val),
      .we      (wr_en),
      .waddr   (wr_addr),
      .wdata   (wr_data)
   );

   // Decode and execute in one pass; anything not recognised leaves wr_en low and falls through to pc+4.
   always_comb begin
      pc_d    = pc_plus4;
      wr_en   = 1'b0;
      wr_addr = rd;
      wr_data = '0;
      case (opcode)
         OP_SPECIAL: begin
            case (funct)
               FN_ADDU: begin wr_en = 1'b1; wr_data = rs_val + rt_val; end
               FN_SUBU: begin wr_en = 1'b1; wr_data = rs_val - rt_val; end
               FN_AND:  begin wr_en = 1'b1; wr_data = rs_val & rt_val; end
               FN_OR:   begin wr_en = 1'b1; wr_data = rs_val | rt_val; end
               FN_XOR:  begin wr_en = 1'b1; wr_data = rs_val ^ rt_val; end
               FN_NOR:  begin wr_en = 1'b1; wr_data = ~(rs_val | rt_val); end
               FN_SLT:  begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
               FN_SLTU: begin wr_en = 1'b1; wr_data = {31'd0, rs_val < rt_val}; end
`ifdef SOPC_SHIFT_EN
               FN_SLL:  begin wr_en = 1'b1; wr_data = rt_val << shamt; end
               FN_SRL:  begin wr_en = 1'b1; wr_data = rt_val >> shamt; end
               FN_SRA:  begin wr_en = 1'b1; wr_data = $unsigned($signed(rt_val) >>> shamt); end
               FN_SLLV: begin wr_en = 1'b1; wr_data = rt_val << rs_val[4:0]; end
               FN_SRLV: begin wr_en = 1'b1; wr_data = rt_val >> rs_val[4:0]; end
               FN_SRAV: begin wr_en = 1'b1; wr_data = $unsigned($signed(rt_val) >>> rs_val[4:0]); end
`endif
               default: ;
            endcase
         end
         OP_ADDIU: begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val + imm_sext; end
         OP_SLTI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = {31'd0, $signed(rs_val) < $signed(imm_sext)}; end
         OP_ANDI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val & imm_zext; end
         OP_ORI:   begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val | imm_zext; end
         OP_XORI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = rs_val ^ imm_zext; end
         OP_LUI:   begin wr_en = 1'b1; wr_addr = rt; wr_data = {instr[15:0], 16'd0}; end
         OP_BEQ:   begin if (rs_val == rt_val) pc_d = branch_target; end
         OP_BNE:   begin if (rs_val != rt_val) pc_d = branch_target; end
         OP_J:     begin pc_d = jump_target; end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule


module mips_sopc (
   input logic clock,
   input logic reset
);

   logic [31:0] instr;
   logic [9:0]  imem_index;

   mips_sopc_rom rom (
      .word_index (imem_index),
      .data       (instr)
   );

   mips_sopc_cpu cpu (
      .clock      (clock),
      .reset      (reset),
      .instr      (instr),
      .imem_index (imem_index)
   );

endmodule

// File: tb/tb_mips_sopc.sv
// tb_mips_sopc: runs directed and random programs on mips_sopc and compares the register file
// against an instruction-level model after every executed instruction.

module tb_mips_sopc;

   logic clock;
   logic reset;

   int checkCount;
   int passCount;

   logic [31:0] modelRom [0:1023];
   logic [31:0] modelReg [0:31];
   logic [31:0] modelPc;

   mips_sopc dut (
      .clock (clock),
      .reset (reset)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] encR(input int rs, input int rt, input int rd, input int sh, input int fn);
      return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
   endfunction

   function automatic logic [31:0] encI(input int op, input int rs, input int rt, input int imm);
      return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
   endfunction

   function automatic logic [31:0] encJ(input int idx);
      return {6'd2, idx[25:0]};
   endfunction

   // Architectural model: one call executes the instruction at modelPc.
   task automatic modelStep();
      logic [31:0] ins;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [4:0]  sh;
      logic [4:0]  dest;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sext;
      logic [31:0] zext;
      logic [31:0] result;
      logic [31:0] nextPc;
      bit          writes;
      ins    = modelRom[modelPc[11:2]];
      op     = ins[31:26];
      fn     = ins[5:0];
      sh     = ins[10:6];
      a      = modelReg[ins[25:21]];
      b      = modelReg[ins[20:16]];
      sext   = {{16{ins[15]}}, ins[15:0]};
      zext   = {16'd0, ins[15:0]};
      nextPc = modelPc + 32'd4;
      result = 32'd0;
      writes = 1'b0;
      dest   = ins[20:16];
      if (op == 6'd0) begin
         dest   = ins[15:11];
         writes = 1'b1;
         case (fn)
            6'h21: result = a + b;
            6'h23: result = a - b;
            6'h24: result = a & b;
            6'h25: result = a | b;
            6'h26: result = a ^ b;
            6'h27: result = ~(a | b);
            6'h2A: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: result = (a < b) ? 32'd1 : 32'd0;
`ifdef SOPC_SHIFT_EN
            6'h00: result = b << sh;
            6'h02: result = b >> sh;
            6'h03: result = $signed(b) >>> sh;
            6'h04: result = b << a[4:0];
            6'h06: result = b >> a[4:0];
            6'h07: result = $signed(b) >>> a[4:0];
`endif
            default: writes = 1'b0;
         endcase
      end else begin
         case (op)
            6'h09: begin writes = 1'b1; result = a + sext; end
            6'h0A: begin writes = 1'b1; result = ($signed(a) < $signed(sext)) ? 32'd1 : 32'd0; end
            6'h0C: begin writes = 1'b1; result = a & zext; end
            6'h0D: begin writes = 1'b1; result = a | zext; end
            6'h0E: begin writes = 1'b1; result = a ^ zext; end
            6'h0F: begin writes = 1'b1; result = zext << 16; end
            6'h04: if (a == b) nextPc = modelPc + 32'd4 + (sext << 2);
            6'h05: if (a != b) nextPc = modelPc + 32'd4 + (sext << 2);
            6'h02: nextPc = {nextPc[31:28], ins[25:0], 2'b00};
            default: ;
         endcase
      end
      if (writes && dest != 5'd0) modelReg[dest] = result;
      modelPc = nextPc;
   endtask

   task automatic modelReset();
      modelPc = 32'd0;
      for (int r = 0; r < 32; r++) modelReg[r] = 32'd0;
   endtask

   task automatic loadRom();
      for (int i = 0; i < 1024; i++) dut.rom.storage[i] = modelRom[i];
   endtask

   task automatic compareAll(input string tag);
      for (int r = 0; r < 32; r++) begin
         checkOutput($sformatf("%s r%0d", tag, r), dut.cpu.register.storage[r], modelReg[r]);
      end
   endtask

   task automatic checkAllZero(input string tag);
      for (int r = 1; r < 32; r++) begin
         checkOutput($sformatf("%s r%0d", tag, r), dut.cpu.register.storage[r], 32'd0);
      end
   endtask

   // Each cycle: the DUT and the model both execute one instruction, then compare away from the edge.
   task automatic runCycles(input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         @(posedge clock);
         modelStep();
         @(negedge clock);
         compareAll($sformatf("%s c%0d", tag, c));
      end
   endtask

   // Hold reset while the ROM is reloaded, then release on a falling edge.
   task automatic applyStimulus(input int runLen, input string tag);
      @(negedge clock);
      reset = 1'b1;
      loadRom();
      modelReset();
      @(negedge clock);
      checkAllZero({tag, " rst"});
      reset = 1'b0;
      runCycles(runLen, tag);
   endtask

   function automatic logic [31:0] randomInstr();
      int kind;
      int rs;
      int rt;
      int rd;
      int pick;
      kind = $urandom_range(0, 9);
      rs   = $urandom_range(0, 7);
      rt   = $urandom_range(0, 7);
      rd   = $urandom_range(0, 7);
      pick = $urandom_range(0, 7);
      case (kind)
         0, 1, 2, 3: begin
            case (pick)
               0: return encR(rs, rt, rd, 0, 'h21);
               1: return encR(rs, rt, rd, 0, 'h23);
               2: return encR(rs, rt, rd, 0, 'h24);
               3: return encR(rs, rt, rd, 0, 'h25);
               4: return encR(rs, rt, rd, 0, 'h26);
               5: return encR(rs, rt, rd, 0, 'h27);
               6: return encR(rs, rt, rd, 0, 'h2A);
               default: return encR(rs, rt, rd, 0, 'h2B);
            endcase
         end
         4, 5: begin
            case (pick)
               0, 1: return encI('h09, rs, rt, int'($urandom_range(0, 65535)));
               2: return encI('h0A, rs, rt, int'($urandom_range(0, 65535)));
               3: return encI('h0C, rs, rt, int'($urandom_range(0, 65535)));
               4: return encI('h0D, rs, rt, int'($urandom_range(0, 65535)));
               5: return encI('h0E, rs, rt, int'($urandom_range(0, 65535)));
               default: return encI('h0F, rs, rt, int'($urandom_range(0, 65535)));
            endcase
         end
         6: begin
            case (pick)
               0, 1: return encR(rs, rt, rd, int'($urandom_range(0, 31)), 'h00);
               2: return encR(rs, rt, rd, int'($urandom_range(0, 31)), 'h02);
               3: return encR(rs, rt, rd, int'($urandom_range(0, 31)), 'h03);
               4: return encR(rs, rt, rd, 0, 'h04);
               5: return encR(rs, rt, rd, 0, 'h06);
               default: return encR(rs, rt, rd, 0, 'h07);
            endcase
         end
         7: return encI((pick < 4) ? 'h04 : 'h05, rs, rt, int'($urandom_range(0, 4)));
         8: return $urandom();
         default: return encJ(int'($urandom_range(14, 47)));
      endcase
   endfunction

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset      = 1'b1;
      modelReset();

      // Reset hold over arbitrary ROM content; word 0 is made recognisable.
      for (int i = 0; i < 1024; i++) modelRom[i] = $urandom();
      modelRom[0] = encI('h0D, 0, 1, 'hABCD);
      loadRom();
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         for (int r = 1; r < 8; r++) begin
            checkOutput($sformatf("hold c%0d r%0d", c, r), dut.cpu.register.storage[r], 32'd0);
         end
      end
      reset = 1'b0;
      @(posedge clock);
      modelStep();
      @(negedge clock);
      checkOutput("first word r1", dut.cpu.register.storage[1], 32'h0000ABCD);
      compareAll("first word");
      runCycles(20, "randrom");

      // Directed program covering immediates, R-type, $0, branches, loop, shifts, j 0.
      for (int i = 0; i < 1024; i++) modelRom[i] = 32'd0;
      modelRom[0]  = encI('h0D, 0, 1, 'h1100);
      modelRom[1]  = encI('h0D, 1, 2, 'h0020);
      modelRom[2]  = encI('h0F, 0, 3, 'h1234);
      modelRom[3]  = encI('h09, 0, 4, -1);
      modelRom[4]  = encI('h0D, 0, 8, 'hFF00);
      modelRom[5]  = encI('h0F, 0, 9, 'h00FF);
      modelRom[6]  = encI('h0D, 9, 9, 'h00FF);
      modelRom[7]  = encR(8, 9, 10, 0, 'h24);
      modelRom[8]  = encR(8, 9, 11, 0, 'h25);
      modelRom[9]  = encR(8, 9, 12, 0, 'h26);
      modelRom[10] = encR(8, 9, 13, 0, 'h27);
      modelRom[11] = encR(0, 9, 14, 0, 'h23);
      modelRom[12] = encR(4, 0, 15, 0, 'h2A);
      modelRom[13] = encR(4, 0, 16, 0, 'h2B);
      modelRom[14] = encI('h0D, 0, 17, 'h0055);
      modelRom[15] = encI('h0D, 0, 0, 'hFFFF);
      modelRom[16] = encR(0, 0, 17, 0, 'h25);
      modelRom[17] = encI('h04, 0, 0, 2);
      modelRom[18] = encI('h0D, 0, 18, 1);
      modelRom[19] = encI('h0D, 0, 18, 2);
      modelRom[20] = encI('h0D, 0, 19, 3);
      modelRom[21] = encI('h05, 0, 0, 1);
      modelRom[22] = encI('h0D, 0, 20, 7);
      modelRom[23] = encI('h09, 0, 21, 0);
      modelRom[24] = encI('h0D, 0, 22, 5);
      modelRom[25] = encI('h09, 21, 21, 1);
      modelRom[26] = encI('h05, 21, 22, -2);
      modelRom[27] = encI('h0F, 0, 23, 'h8000);
      modelRom[28] = encI('h0D, 23, 23, 1);
      modelRom[29] = encR(0, 23, 24, 4, 'h00);
      modelRom[30] = encR(0, 23, 25, 1, 'h02);
      modelRom[31] = encR(0, 23, 26, 1, 'h03);
      modelRom[32] = encJ(0);
      applyStimulus(90, "dir");
      checkOutput("ori r1",   dut.cpu.register.storage[1],  32'h00001100);
      checkOutput("ori r2",   dut.cpu.register.storage[2],  32'h00001120);
      checkOutput("lui r3",   dut.cpu.register.storage[3],  32'h12340000);
      checkOutput("addiu r4", dut.cpu.register.storage[4],  32'hFFFFFFFF);
      checkOutput("and",      dut.cpu.register.storage[10], 32'h00000000);
      checkOutput("or",       dut.cpu.register.storage[11], 32'h00FFFFFF);
      checkOutput("xor",      dut.cpu.register.storage[12], 32'h00FFFFFF);
      checkOutput("nor",      dut.cpu.register.storage[13], 32'hFF000000);
      checkOutput("subu",     dut.cpu.register.storage[14], 32'hFF00FF01);
      checkOutput("slt",      dut.cpu.register.storage[15], 32'd1);
      checkOutput("sltu",     dut.cpu.register.storage[16], 32'd0);
      checkOutput("r0 zero",  dut.cpu.register.storage[0],  32'd0);
      checkOutput("or zero",  dut.cpu.register.storage[17], 32'd0);
      checkOutput("beq skip", dut.cpu.register.storage[18], 32'd0);
      checkOutput("beq tgt",  dut.cpu.register.storage[19], 32'd3);
      checkOutput("bne fall", dut.cpu.register.storage[20], 32'd7);
      checkOutput("loop r21", dut.cpu.register.storage[21], 32'd5);
`ifdef SOPC_SHIFT_EN
      checkOutput("sll", dut.cpu.register.storage[24], 32'h00000010);
      checkOutput("srl", dut.cpu.register.storage[25], 32'h40000000);
      checkOutput("sra", dut.cpu.register.storage[26], 32'hC0000000);
`else
      checkOutput("sll nop", dut.cpu.register.storage[24], 32'd0);
      checkOutput("srl nop", dut.cpu.register.storage[25], 32'd0);
      checkOutput("sra nop", dut.cpu.register.storage[26], 32'd0);
`endif

      // Asynchronous reset in the middle of the directed program, then restart from word 0.
      @(negedge clock);
      #2 reset = 1'b1;
      #1 checkAllZero("async rst");
      modelReset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         checkAllZero($sformatf("rst hold c%0d", c));
      end
      reset = 1'b0;
      runCycles(10, "restart");

      // Random programs: seed r1..r7 with lui/ori pairs, then a random instruction mix.
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 1024; i++) modelRom[i] = 32'd0;
         for (int r = 1; r < 8; r++) begin
            modelRom[2*r-2] = encI('h0F, 0, r, int'($urandom_range(0, 65535)));
            modelRom[2*r-1] = encI('h0D, r, r, int'($urandom_range(0, 65535)));
         end
         for (int i = 14; i < 48; i++) modelRom[i] = randomInstr();
         applyStimulus(60, $sformatf("rnd%0d", t));
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
